// File: rtl/sync_word_serializer_to_mtd3l_if.sv
// Producer-side word handshake for the MTD3L word serializer.
// The producer drives a parallel word with a valid flag; the serializer
// answers with ready while its single-entry holding register is empty.
interface sync_word_serializer_to_mtd3l_if #(
    parameter int WIDTH = 612
) ();
    logic [WIDTH-1:0] in_word;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_word,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_word,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sync_word_serializer_to_mtd3l.sv
// Word serializer feeding the sync-to-MTD3L serial-to-parallel stage.
// A word is parked in a one-entry holding register, then shifted out
// LSB-first on data_in/data_in_valid, followed by a one-cycle word_en that
// toggles the downstream LINK token. Each word is paced by the asynchronous
// data_req level: a word only starts on a fresh high after the previous
// token was seen consumed (req low). data_in_valid and word_en drive ICG
// enables downstream, so they come straight from flops.
module sync_word_serializer_to_mtd3l #(
    parameter int WIDTH       = 612,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              reset_n,
    sync_word_serializer_to_mtd3l_if.slave    prod,
    input  logic                              data_req,
    output logic                              data_in,
    output logic                              data_in_valid,
    output logic                              word_en,
    output logic                              busy,
    output logic                              err,
    output logic [15:0]                       word_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic [WIDTH-1:0]       hold_r;
    logic                   hold_full_r;
    logic                   accept_s;
    logic                   load_s;
    logic [WIDTH-1:0]       sh_r;
    logic [WIDTH-1:0]       sh_nxt;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [TO_W-1:0]        to_cnt_r;
    logic [TO_W-1:0]        to_cnt_nxt;
    logic                   data_in_r;
    logic                   data_in_nxt;
    logic                   data_in_valid_r;
    logic                   data_in_valid_nxt;
    logic                   word_en_r;
    logic                   word_en_nxt;
    logic                   busy_r;
    logic                   err_r;
    logic                   err_nxt;
    logic [15:0]            word_cnt_r;
    logic [15:0]            word_cnt_nxt;

    assign req_s         = sync_r[SYNC_STAGES-1];
    assign accept_s      = prod.in_valid & ~hold_full_r;
    assign prod.in_ready = ~hold_full_r;

    assign data_in       = data_in_r;
    assign data_in_valid = data_in_valid_r;
    assign word_en       = word_en_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign word_cnt      = word_cnt_r;

    // Bring the asynchronous data_req level into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], data_req};
        end
    end

    // Single-entry holding register: filled on accept, emptied by the IDLE load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= prod.in_word;
            hold_full_r <= 1'b1;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; SHIFT length is fixed and ignores req.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r && req_s) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(WIDTH)) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!req_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; the shifter moves right so bit 0 is always next out.
    always_comb begin
        load_s            = 1'b0;
        sh_nxt            = sh_r;
        cnt_nxt           = cnt_r;
        to_cnt_nxt        = to_cnt_r;
        data_in_nxt       = data_in_r;
        data_in_valid_nxt = data_in_valid_r;
        word_en_nxt       = word_en_r;
        err_nxt           = err_r;
        word_cnt_nxt      = word_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r && req_s) begin
                    load_s            = 1'b1;
                    sh_nxt            = {1'b0, hold_r[WIDTH-1:1]};
                    data_in_nxt       = hold_r[0];
                    data_in_valid_nxt = 1'b1;
                    cnt_nxt           = CNT_W'(1);
                end else begin
                    data_in_valid_nxt = 1'b0;
                    word_en_nxt       = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(WIDTH)) begin
                    data_in_valid_nxt = 1'b0;
                    word_en_nxt       = 1'b1;
                end else begin
                    data_in_nxt = sh_r[0];
                    sh_nxt      = {1'b0, sh_r[WIDTH-1:1]};
                    cnt_nxt     = cnt_r + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                word_en_nxt  = 1'b0;
                word_cnt_nxt = word_cnt_r + 16'd1;
                to_cnt_nxt   = {TO_W{1'b0}};
            end
            ST_WAIT_ACK: begin
                if (to_cnt_r != TO_W'(ACK_TIMEOUT)) begin
                    to_cnt_nxt = to_cnt_r + TO_W'(1);
                end else begin
                    to_cnt_nxt = to_cnt_r;
                end
                if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
                    err_nxt = 1'b1;
                end else begin
                    err_nxt = err_r;
                end
            end
            default: begin
                data_in_valid_nxt = 1'b0;
                word_en_nxt       = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_r            <= {WIDTH{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            to_cnt_r        <= {TO_W{1'b0}};
            data_in_r       <= 1'b0;
            data_in_valid_r <= 1'b0;
            word_en_r       <= 1'b0;
            busy_r          <= 1'b0;
            err_r           <= 1'b0;
            word_cnt_r      <= 16'd0;
        end else begin
            sh_r            <= sh_nxt;
            cnt_r           <= cnt_nxt;
            to_cnt_r        <= to_cnt_nxt;
            data_in_r       <= data_in_nxt;
            data_in_valid_r <= data_in_valid_nxt;
            word_en_r       <= word_en_nxt;
            busy_r          <= (state_nxt != ST_IDLE);
            err_r           <= err_nxt;
            word_cnt_r      <= word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sync_word_serializer_to_mtd3l.sv
// Bench for the MTD3L word serializer (WIDTH=8, ACK_TIMEOUT=16).
// Accepted words are pushed into a scoreboard queue; a monitor rebuilds each
// serial word from data_in while data_in_valid is high and compares it on word_en.
module tb_sync_word_serializer_to_mtd3l;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int ATO = 16;

    logic        clk;
    logic        reset_n;
    logic        data_req;
    logic        data_in;
    logic        data_in_valid;
    logic        word_en;
    logic        busy;
    logic        err;
    logic [15:0] word_cnt;

    int          pass_cnt;
    int          chk_cnt;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_wcnt;

    sync_word_serializer_to_mtd3l_if #(.WIDTH(W)) ifc ();

    sync_word_serializer_to_mtd3l #(
        .WIDTH(W),
        .SYNC_STAGES(SS),
        .ACK_TIMEOUT(ATO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .prod(ifc),
        .data_req(data_req),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .word_en(word_en),
        .busy(busy),
        .err(err),
        .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        chk_cnt++;
        if (got === expv) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    // Offer one word; returns how many negedges it waited for in_ready.
    task automatic send(input logic [7:0] w, output int stalls);
        stalls = 0;
        @(negedge clk);
        ifc.in_word  = w;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && stalls < 400) begin
            @(negedge clk);
            stalls++;
        end
        check("send_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge clk);
        if (ifc.in_ready) exp_q.push_back(w);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_we(input string name);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            seen = word_en;
            n++;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Downstream consumes the token: req low for a few cycles, then high again.
    task automatic ack_cycle();
        @(negedge clk);
        data_req = 1'b0;
        repeat (3) @(negedge clk);
        data_req = 1'b1;
    endtask

    initial begin
        int st;
        int st2;
        int st3;
        int n;
        int cnt_dv;
        pass_cnt     = 0;
        chk_cnt      = 0;
        exp_wcnt     = 16'd0;
        reset_n      = 1'b0;
        data_req     = 1'b0;
        ifc.in_word  = 8'h00;
        ifc.in_valid = 1'b0;

        fork
            begin : monitor
                int   nbits;
                logic [7:0] acc;
                logic prev_dv;
                logic pend;
                nbits   = 0;
                acc     = 8'h00;
                prev_dv = 1'b0;
                pend    = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!reset_n) begin
                        nbits    = 0;
                        acc      = 8'h00;
                        prev_dv  = 1'b0;
                        pend     = 1'b0;
                        exp_wcnt = 16'd0;
                    end else begin
                        if (pend) begin
                            check("word_en_one_cycle", {31'd0, word_en}, 32'd0);
                            check("word_cnt_after_commit", {16'd0, word_cnt}, {16'd0, exp_wcnt});
                            pend = 1'b0;
                        end
                        if (data_in_valid) begin
                            if (nbits < W) acc[nbits] = data_in;
                            nbits++;
                        end
                        if (word_en) begin
                            check("word_en_follows_last_bit", {31'd0, prev_dv}, 32'd1);
                            check("serial_bit_count", nbits, W);
                            check("word_pending_at_word_en", {31'd0, (exp_q.size() != 0)}, 32'd1);
                            if (exp_q.size() != 0) begin
                                check("serial_word", {24'd0, acc}, {24'd0, exp_q.pop_front()});
                            end
                            exp_wcnt = exp_wcnt + 16'd1;
                            pend  = 1'b1;
                            nbits = 0;
                            acc   = 8'h00;
                        end
                        prev_dv = data_in_valid;
                    end
                end
            end
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_data_in", {31'd0, data_in}, 32'd0);
        check("rst_data_in_valid", {31'd0, data_in_valid}, 32'd0);
        check("rst_word_en", {31'd0, word_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        reset_n = 1'b1;

        // Single word 0xA5: serial 1,0,1,0,0,1,0,1 then word_en, word_cnt=1.
        data_req = 1'b1;
        repeat (3) @(negedge clk);
        send(8'hA5, st);
        wait_we("single_word_en");
        ack_cycle();
        repeat (4) @(negedge clk);
        check("single_word_cnt", {16'd0, word_cnt}, 32'd1);
        check("single_idle", {31'd0, busy}, 32'd0);

        // Pacing: second word held while data_req stays low.
        send(8'h3C, st);
        wait_we("pace_first_word_en");
        @(negedge clk);
        data_req = 1'b0;
        send(8'h5A, st);
        cnt_dv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_in_valid) cnt_dv++;
        end
        check("pace_no_valid_while_req_low", cnt_dv, 0);
        data_req = 1'b1;
        repeat (SS) @(negedge clk);
        check("pace_valid_before_sync", {31'd0, data_in_valid}, 32'd0);
        @(negedge clk);
        check("pace_valid_at_sync_plus_1", {31'd0, data_in_valid}, 32'd1);
        wait_we("pace_second_word_en");
        ack_cycle();
        repeat (4) @(negedge clk);

        // Holding buffer: three words back-to-back.
        fork
            begin
                send(8'h96, st);
                send(8'h0F, st2);
                send(8'hC3, st3);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_we("hold_word_en");
                    ack_cycle();
                end
            end
        join
        check("hold_second_accept_during_shift", st2, 1);
        check("hold_third_stalled", {31'd0, (st3 > W)}, 32'd1);
        repeat (4) @(negedge clk);
        check("hold_word_cnt", {16'd0, word_cnt}, 32'd6);
        check("err_clear_before_timeout", {31'd0, err}, 32'd0);

        // Timeout with data_req held high after commit.
        send(8'h81, st);
        wait_we("timeout_word_en");
        repeat (ATO) @(negedge clk);
        check("timeout_err_not_yet", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("timeout_err_set", {31'd0, err}, 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (word_en) n++;
        end
        check("timeout_no_extra_word_en", n, 0);
        data_req = 1'b0;
        repeat (4) @(negedge clk);
        data_req = 1'b1;
        repeat (4) @(negedge clk);
        check("timeout_err_sticky", {31'd0, err}, 32'd1);
        check("timeout_back_to_idle", {31'd0, busy}, 32'd0);
        check("timeout_no_new_word", {31'd0, data_in_valid}, 32'd0);

        // Reset in the middle of the shift (bit 3 of 8).
        send(8'hE7, st);
        n = 0;
        while (!data_in_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_shift_started", {31'd0, data_in_valid}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_data_in", {31'd0, data_in}, 32'd0);
        check("midrst_data_in_valid", {31'd0, data_in_valid}, 32'd0);
        check("midrst_word_en", {31'd0, word_en}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("midrst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(8'h6B, st);
        wait_we("midrst_next_word_en");
        ack_cycle();
        repeat (4) @(negedge clk);
        check("midrst_word_cnt_after", {16'd0, word_cnt}, 32'd1);

        // Wrap of the committed-word counter.
        force dut.word_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt_r;
        exp_wcnt = 16'hFFFF;
        send(8'h42, st);
        wait_we("wrap_word_en");
        @(negedge clk);
        check("wrap_word_cnt", {16'd0, word_cnt}, 32'd0);
        ack_cycle();
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sync_word_serializer_to_mtd3l.md
# sync_word_serializer_to_mtd3l

Synchronous-domain word serializer that feeds the sync-to-MTD3L serial-to-parallel stage. It accepts a WIDTH-bit parallel word from a synchronous producer over a valid/ready handshake. It shifts the word out LSB-first on `data_in`/`data_in_valid`, then issues a one-cycle `word_en` to hand the word to the MTD3L pipeline. It paces every word on the asynchronous `data_req` level returned by the MTD3L stage, which it synchronizes internally.

## Interface
- `WIDTH`, 612, word width in bits; must equal the downstream stage's `width`.
- `SYNC_STAGES`, 2, flop count of the `data_req` synchronizer; minimum 2.
- `ACK_TIMEOUT`, 1024, cycles allowed in WAIT_ACK before `err` sets.
- `clk`  in  1  single clock; all flops rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  WIDTH  parallel word from the producer.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  holding register empty, i.e. `~hold_full`.
- `data_req`  in  1  asynchronous level from MTD3L (`ki & ko`); high means the stage can take a word.
- `data_in`  out  1  serial bit to the downstream capture shift register.
- `data_in_valid`  out  1  serial bit valid; drives the downstream clock-gate enable.
- `word_en`  out  1  one-cycle pulse that toggles the downstream LINK token.
- `busy`  out  1  FSM is not in IDLE.
- `err`  out  1  sticky flag: the ACK timeout expired.
- `word_cnt`  out  16  count of committed words; wraps at 2^16.

## Operation
- All outputs except `in_ready` are registered. `data_in_valid` and `word_en` feed ICG enables, so they must be glitch-free flop outputs.
- **Holding register.** An accept occurs when `in_valid & in_ready`; the word is captured into `hold_q` and `hold_full` sets.
  - Only one word can wait while another is shifting.
- **Synchronizer.** `req_s` is `data_req` passed through `SYNC_STAGES` flops, all reset to 0.
- **FSM states:** IDLE, SHIFT, COMMIT, WAIT_ACK.
- **IDLE:** if `hold_full & req_s`:
  - load `sh_q <= hold_q`;
  - clear `hold_full`;
  - drive `data_in <= hold_q[0]` and `data_in_valid <= 1`;
  - set `cnt <= 1` and go to SHIFT.
- **SHIFT:** each cycle drive `data_in <= sh_q[cnt]`, then `cnt++`.
  - When `cnt == WIDTH`: set `data_in_valid <= 0` and `word_en <= 1`, then go to COMMIT.
  - The cycle count of SHIFT is fixed; `req_s` is ignored during SHIFT.
- **COMMIT:**
  - `word_en <= 0`;
  - `word_cnt++`;
  - go to WAIT_ACK.
- **WAIT_ACK:** wait for `req_s == 0`, meaning the downstream consumed the token. Then go to IDLE.
  - A new word is never started on a stale `data_req` high.
  - `to_cnt` increments every WAIT_ACK cycle. When it reaches `ACK_TIMEOUT`, `err` sets and the FSM keeps waiting.
  - `to_cnt` clears on entry to WAIT_ACK.
- **Simultaneous events:**
  - An accept in the same cycle that IDLE moves `hold_q` to `sh_q` cannot happen, because `in_ready` is 0 in that cycle.
  - An accept during SHIFT, COMMIT or WAIT_ACK is allowed.
- **Bit order.** Bit `i` of `in_word` is the i-th serial bit. After WIDTH shifts it lands in downstream `q[i]`, which is rail1 of downstream bit `i`.
- **Reset mid-operation.** Any in-flight or held word is discarded and the FSM returns to IDLE. `word_cnt`, `err`, all counters and the synchronizer clear.

## Timing
- **Reset values:**
  - `data_in` = 0, `data_in_valid` = 0, `word_en` = 0, `busy` = 0, `err` = 0, `word_cnt` = 0;
  - `in_ready` = 1, `hold_full` = 0;
  - state IDLE.
- **Request latency.** `data_req` rising to `req_s` high takes `SYNC_STAGES` edges.
- **Per-word timing**, for a word held and `req_s` high at edge E:
  - `data_in_valid` is high for exactly WIDTH cycles, from edge E through E+WIDTH.
  - `word_en` is high for exactly one cycle, starting at edge E+WIDTH.
  - `word_cnt` updates at E+WIDTH+1.
- **Back-to-back throughput.** Minimum word period is WIDTH+2 cycles plus the round trip of `data_req` falling and rising through the synchronizer.
- **Accept latency.** `in_ready` falls the cycle after an accept and rises the cycle after the IDLE load.

## Test plan
- **Reset / single word.** Hold `reset_n`=0, then release; WIDTH=8; send `in_word`=0xA5 with `data_req`=1.
  - Serial `data_in` sequence 1,0,1,0,0,1,0,1 over exactly 8 valid cycles.
  - `word_en` pulses once, the cycle after the last valid cycle.
  - `word_cnt`=1.
- **Pacing.** Keep `data_req`=0 after the first commit, with a second word held.
  - No `data_in_valid` until `data_req` falls and rises again; the second word then starts SYNC_STAGES+1 cycles after the rise.
- **Holding buffer.** Offer three words back-to-back.
  - The first is accepted, the second is accepted during SHIFT, and the third stalls (`in_ready`=0) until the IDLE load.
  - Serial output order is word 1, then 2, then 3.
- **Timeout.** Set ACK_TIMEOUT=16 and hold `data_req`=1 after commit.
  - `err` rises on the 16th WAIT_ACK cycle and stays high after `data_req` toggles.
  - No extra `word_en` pulse is produced.
- **Reset mid-shift.** Assert `reset_n`=0 at bit 3 of 8.
  - All outputs return to reset values asynchronously; `word_cnt`=0.
  - The next word after release shifts in full.
- **Wrap.** Force `word_cnt`=0xFFFF, then commit one word → `word_cnt`=0x0000.
